// File: rtl/sensor_scan_pkg.sv
// Shared types and constants for the sensor scan hub.
//   mode_e      : operating mode encoding of mode_i (11 is reserved and behaves as manual)
//   state_e     : scan FSM states
//   MAX_TRIES   : SAMPLE cycles allowed before a capture is flagged unstable
//   SYNC_STAGES : depth of the input synchroniser
package sensor_scan_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_SINGLE = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        SAMPLE,
        CAPTURE
    } state_e;

    localparam int unsigned MAX_TRIES   = 4;
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sensor_scan_hub_if.sv
// Signal bundle between the sensor macros / control and the scan hub.
//   master : drives channel words and controls, observes captured output
//   slave  : the hub itself
// Inputs : ch_data_i (N_CH*W, channel k at [k*W +: W]), mode_i, sel_i, dwell_i, start_i
// Outputs: data_o, ch_o, valid_o, unstable_o, busy_o, sweep_done_o
interface sensor_scan_hub_if #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned DWELL_W = 8
);
    localparam int unsigned SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0]  ch_data_i;
    logic [1:0]         mode_i;
    logic [SEL_W-1:0]   sel_i;
    logic [DWELL_W-1:0] dwell_i;
    logic               start_i;
    logic [W-1:0]       data_o;
    logic [SEL_W-1:0]   ch_o;
    logic               valid_o;
    logic               unstable_o;
    logic               busy_o;
    logic               sweep_done_o;

    modport master (
        output ch_data_i, mode_i, sel_i, dwell_i, start_i,
        input  data_o, ch_o, valid_o, unstable_o, busy_o, sweep_done_o
    );

    modport slave (
        input  ch_data_i, mode_i, sel_i, dwell_i, start_i,
        output data_o, ch_o, valid_o, unstable_o, busy_o, sweep_done_o
    );

endinterface

// File: rtl/sensor_sync2.sv
// Multi-bit flop-chain synchroniser (SYNC_STAGES deep) for quasi-static sensor words.
//   clk, rst : clock, asynchronous active-high reset (all stages clear to 0)
//   d_i      : asynchronous input word
//   q_o      : synchronised word
module sensor_sync2
    import sensor_scan_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_q [SYNC_STAGES];
    logic [Width-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sensor_scan_hub.sv
// Sensor scan hub: synchronises N_CH asynchronous sensor words and either passes one
// through (manual), scans all channels round-robin (auto) or runs one triggered sweep
// (single-shot). Each capture is tagged with channel, strobe and a stability flag.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sensor_scan_hub_if (controls in, captured word out)
module sensor_scan_hub
    import sensor_scan_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned DWELL_W = 8
) (
    input logic              clk,
    input logic              rst,
    sensor_scan_hub_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES);

    logic [N_CH*W-1:0] sync_word;
    logic [W-1:0]      words [N_CH];

    sensor_sync2 #(
        .Width(N_CH * W)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(bus.ch_data_i),
        .q_o(sync_word)
    );

    state_e             state_q, state_d;
    logic [1:0]         run_mode_q, run_mode_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [W-1:0]       prev_q, prev_d;
    logic [W-1:0]       data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               valid_q, valid_d;
    logic               unstable_q, unstable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [W-1:0]       cur_word, sel_word;
    logic [SEL_W-1:0]   sel_ch;
    logic [DWELL_W-1:0] dwell_load;
    logic               manual, start_req, abort, last_ch, last_single;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            words[k] = sync_word[k*W +: W];
        end
    end

    always_comb begin
        // Out-of-range selects fold onto the top channel.
        if (32'(bus.sel_i) >= N_CH) begin
            sel_ch = SEL_W'(N_CH - 1);
        end else begin
            sel_ch = bus.sel_i;
        end
        sel_word    = words[sel_ch];
        cur_word    = words[ptr_q];
        // Counter is loaded with cycles-1 so a zero dwell still spends one cycle settling.
        dwell_load  = (bus.dwell_i == '0) ? '0 : bus.dwell_i - 1'b1;
        manual      = !(bus.mode_i == MODE_AUTO || bus.mode_i == MODE_SINGLE);
        start_req   = (bus.mode_i == MODE_AUTO) || (bus.mode_i == MODE_SINGLE && bus.start_i);
        abort       = (bus.mode_i != run_mode_q);
        last_ch     = (ptr_q == SEL_W'(N_CH - 1));
        last_single = last_ch && (run_mode_q == MODE_SINGLE);
    end

    always_comb begin
        state_d     = state_q;
        run_mode_d  = run_mode_q;
        ptr_d       = ptr_q;
        dwell_cnt_d = dwell_cnt_q;
        tries_d     = '0;
        prev_d      = cur_word;
        data_d      = data_q;
        ch_d        = ch_q;
        unstable_d  = unstable_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d     = DWELL;
                    run_mode_d  = bus.mode_i;
                    ptr_d       = '0;
                    dwell_cnt_d = dwell_load;
                end else if (manual) begin
                    data_d     = sel_word;
                    ch_d       = sel_ch;
                    unstable_d = 1'b0;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dwell_cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cur_word == prev_q || tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    // Output registers load here so the strobe is visible during CAPTURE.
                    state_d    = CAPTURE;
                    data_d     = cur_word;
                    ch_d       = ptr_q;
                    unstable_d = (cur_word != prev_q);
                    valid_d    = 1'b1;
                    done_d     = last_single;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = last_ch ? '0 : ptr_q + 1'b1;
                    if (last_single) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = DWELL;
                        dwell_cnt_d = dwell_load;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            run_mode_q  <= MODE_MANUAL;
            ptr_q       <= '0;
            dwell_cnt_q <= '0;
            tries_q     <= '0;
            prev_q      <= '0;
            data_q      <= '0;
            ch_q        <= '0;
            valid_q     <= 1'b0;
            unstable_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_mode_q  <= run_mode_d;
            ptr_q       <= ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
            tries_q     <= tries_d;
            prev_q      <= prev_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
            unstable_q  <= unstable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.ch_o         = ch_q;
    assign bus.valid_o      = valid_q;
    assign bus.unstable_o   = unstable_q;
    assign bus.busy_o       = busy_q;
    assign bus.sweep_done_o = done_q;

endmodule
